// File: rtl/ysyx_24080006_sysctrl.sv
// SYSTEM-instruction sequencer: turns one CSR / ECALL / MRET / FENCE.I op into
// a CSR access, trap pulse or I-cache flush, then returns rd data and redirect.
module ysyx_24080006_sysctrl #(
  parameter bit FENCEI_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [11:0] in_csr_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_rs1_zero,
  input  logic        in_rd_zero,
  input  logic [31:0] in_pc,
  output logic        csr_enable,
  output logic [1:0]  csr_op,
  output logic [11:0] csr_name,
  output logic [31:0] csr_wdata,
  output logic [31:0] csr_pc,
  input  logic [31:0] csr_rdata,
  output logic        ecall,
  output logic        mret,
  output logic        fencei_req,
  input  logic        fencei_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_rd_we,
  output logic [31:0] out_rd_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0]  CSR_READ  = 2'd0;
  localparam logic [1:0]  CSR_WRITE = 2'd1;
  localparam logic [1:0]  CSR_SET   = 2'd2;
  localparam logic [1:0]  CSR_CLEAR = 2'd3;
  localparam logic [11:0] MTVEC     = 12'h305;
  localparam logic [11:0] MEPC      = 12'h341;

  typedef enum logic [2:0] {IDLE, ACCESS, TRAP, RET, FENCE, RESP} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        rd_zero_reg;
  logic [1:0]  op_next;

  assign in_ready = (state_reg == IDLE) & ~reset;

  // Read-only forms (rs1/zimm == 0) must not write the CSR.
  always_comb begin
    op_next = CSR_READ;
    case (in_op)
      3'd0:    op_next = CSR_WRITE;
      3'd1:    op_next = in_rs1_zero ? CSR_READ : CSR_SET;
      3'd2:    op_next = in_rs1_zero ? CSR_READ : CSR_CLEAR;
      default: op_next = CSR_READ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= '0;
      rd_zero_reg    <= 1'b0;
      csr_enable     <= 1'b0;
      csr_op         <= CSR_READ;
      csr_name       <= '0;
      csr_wdata      <= '0;
      csr_pc         <= '0;
      ecall          <= 1'b0;
      mret           <= 1'b0;
      fencei_req     <= 1'b0;
      out_valid      <= 1'b0;
      out_rd_we      <= 1'b0;
      out_rd_data    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            pc_reg      <= in_pc;
            rd_zero_reg <= in_rd_zero;
            case (in_op)
              3'd0, 3'd1, 3'd2: begin
                state_reg  <= ACCESS;
                csr_enable <= 1'b1;
                csr_op     <= op_next;
                csr_name   <= in_csr_addr;
                csr_wdata  <= in_wdata;
              end
              3'd3: begin
                state_reg <= TRAP;
                ecall     <= 1'b1;
                csr_pc    <= in_pc;
                csr_name  <= MTVEC;
              end
              3'd4: begin
                state_reg <= RET;
                mret      <= 1'b1;
                csr_name  <= MEPC;
              end
              3'd5: begin
                state_reg  <= FENCE;
                fencei_req <= FENCEI_EN;
              end
              default: begin
                state_reg      <= RESP;
                out_valid      <= 1'b1;
                out_rd_we      <= 1'b0;
                out_rd_data    <= '0;
                redirect_valid <= 1'b0;
                redirect_pc    <= '0;
              end
            endcase
          end
        end
        ACCESS: begin
          state_reg      <= RESP;
          csr_enable     <= 1'b0;
          csr_op         <= CSR_READ;
          csr_name       <= '0;
          csr_wdata      <= '0;
          out_valid      <= 1'b1;
          out_rd_we      <= ~rd_zero_reg;
          out_rd_data    <= csr_rdata;
          redirect_valid <= 1'b0;
          redirect_pc    <= '0;
        end
        TRAP, RET: begin
          state_reg      <= RESP;
          ecall          <= 1'b0;
          mret           <= 1'b0;
          csr_pc         <= '0;
          csr_name       <= '0;
          out_valid      <= 1'b1;
          out_rd_we      <= 1'b0;
          out_rd_data    <= '0;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_rdata;
        end
        FENCE: begin
          // With the flush disabled there is nothing to wait for.
          if (fencei_ack || !FENCEI_EN) begin
            state_reg      <= RESP;
            fencei_req     <= 1'b0;
            out_valid      <= 1'b1;
            out_rd_we      <= 1'b0;
            out_rd_data    <= '0;
            redirect_valid <= 1'b1;
            redirect_pc    <= pc_reg + 32'd4;
          end
        end
        RESP: begin
          if (out_ready) begin
            state_reg      <= IDLE;
            out_valid      <= 1'b0;
            out_rd_we      <= 1'b0;
            redirect_valid <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_sysctrl.sv
// Self-checking bench for the system-instruction sequencer, with a small CSR
// file model (mtvec, mepc, mstatus) and a response scoreboard.
module tb_ysyx_24080006_sysctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [11:0] in_csr_addr = '0;
  logic [31:0] in_wdata = '0;
  logic        in_rs1_zero = 1'b0;
  logic        in_rd_zero = 1'b0;
  logic [31:0] in_pc = '0;
  logic        csr_enable;
  logic [1:0]  csr_op;
  logic [11:0] csr_name;
  logic [31:0] csr_wdata;
  logic [31:0] csr_pc;
  logic [31:0] csr_rdata;
  logic        ecall;
  logic        mret;
  logic        fencei_req;
  logic        fencei_ack = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_rd_we;
  logic [31:0] out_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ysyx_24080006_sysctrl dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_csr_addr(in_csr_addr), .in_wdata(in_wdata),
    .in_rs1_zero(in_rs1_zero), .in_rd_zero(in_rd_zero), .in_pc(in_pc),
    .csr_enable(csr_enable), .csr_op(csr_op), .csr_name(csr_name),
    .csr_wdata(csr_wdata), .csr_pc(csr_pc), .csr_rdata(csr_rdata),
    .ecall(ecall), .mret(mret),
    .fencei_req(fencei_req), .fencei_ack(fencei_ack),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_we(out_rd_we), .out_rd_data(out_rd_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  // CSR file model: combinational pre-write read, write on csr_enable edge.
  logic [31:0] m_mtvec = '0, m_mepc = '0, m_mstatus = '0;
  logic [31:0] m_old, m_new;
  always_comb begin
    case (csr_name)
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      12'h300: csr_rdata = m_mstatus;
      default: csr_rdata = '0;
    endcase
  end
  always_comb begin
    m_old = csr_rdata;
    case (csr_op)
      2'd1:    m_new = csr_wdata;
      2'd2:    m_new = m_old | csr_wdata;
      2'd3:    m_new = m_old & ~csr_wdata;
      default: m_new = m_old;
    endcase
  end
  always @(posedge clock) begin
    if (csr_enable) begin
      case (csr_name)
        12'h305: m_mtvec   <= m_new;
        12'h341: m_mepc    <= m_new;
        12'h300: m_mstatus <= m_new;
        default: ;
      endcase
    end
  end

  typedef struct packed {
    logic        rd_we;
    logic [31:0] rd_data;
    logic        redir;
    logic [31:0] redir_pc;
  } resp_t;

  resp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sh_mtvec = '0, sh_mepc = '0, sh_mstatus = '0;

  function automatic logic [31:0] sh_rd(input logic [11:0] a);
    case (a)
      12'h305: return sh_mtvec;
      12'h341: return sh_mepc;
      12'h300: return sh_mstatus;
      default: return 32'h0;
    endcase
  endfunction

  task automatic sh_wr(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h305: sh_mtvec = v;
      12'h341: sh_mepc = v;
      12'h300: sh_mstatus = v;
      default: ;
    endcase
  endtask

  // Expected response derived from the bench's own CSR shadow.
  task automatic predict(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                         input logic rs1z, input logic rdz, input logic [31:0] pc);
    resp_t r;
    logic [31:0] old;
    r = '0;
    old = sh_rd(a);
    case (op)
      3'd0: begin r.rd_we = ~rdz; sh_wr(a, wd); end
      3'd1: begin r.rd_we = ~rdz; if (!rs1z) sh_wr(a, old | wd); end
      3'd2: begin r.rd_we = ~rdz; if (!rs1z) sh_wr(a, old & ~wd); end
      3'd3: begin r.redir = 1'b1; r.redir_pc = sh_mtvec; end
      3'd4: begin r.redir = 1'b1; r.redir_pc = sh_mepc; end
      3'd5: begin r.redir = 1'b1; r.redir_pc = pc + 32'd4; end
      default: ;
    endcase
    if (r.rd_we) r.rd_data = old;
    sb.push_back(r);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offers one instruction; returns in the cycle after the handshake.
  task automatic send(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                      input logic rs1z, input logic rdz, input logic [31:0] pc);
    predict(op, a, wd, rs1z, rdz, pc);
    in_valid = 1'b1; in_op = op; in_csr_addr = a; in_wdata = wd;
    in_rs1_zero = rs1z; in_rd_zero = rdz; in_pc = pc;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_in_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, captures the response, then completes the handshake.
  task automatic collect(output resp_t got, output bit ok);
    got = '0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !out_valid; i++) step();
    if (!out_valid) return;
    ok = 1'b1;
    got.rd_we = out_rd_we;
    got.rd_data = out_rd_we ? out_rd_data : 32'h0;
    got.redir = redirect_valid;
    got.redir_pc = redirect_valid ? redirect_pc : 32'h0;
    $display("txn: rd_we=%b rd_data=%h redirect=%b redirect_pc=%h",
             got.rd_we, got.rd_data, got.redir, got.redir_pc);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic logic [148:0] all_outs();
    return {csr_enable, csr_op, csr_name, csr_wdata, csr_pc, ecall, mret, fencei_req,
            out_valid, out_rd_we, out_rd_data, redirect_valid, redirect_pc};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++;
    if (all_outs() !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", all_outs()); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_csr();
    resp_t got, want; bit ok;
    // CSRRW mtvec
    send(3'd0, 12'h305, 32'h80000100, 1'b0, 1'b0, 32'h80000000);
    n_cmp++;
    if ({csr_enable, csr_op, csr_name, csr_wdata} !== {1'b1, 2'd1, 12'h305, 32'h80000100}) begin
      n_bad++; $display("FAIL csrrw_access: got %b %0d %h %h want 1 1 305 80000100",
                        csr_enable, csr_op, csr_name, csr_wdata);
    end
    step();
    n_cmp++;
    if ({csr_enable, out_valid} !== 2'b01) begin
      n_bad++; $display("FAIL csrrw_timing: got en=%b valid=%b want en=0 valid=1", csr_enable, out_valid);
    end
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL csrrw_resp: got %h want %h ok=%b", got, want, ok); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL resp_to_ready: got %b want 1", in_ready); end

    // CSRRS read-back of mtvec
    send(3'd1, 12'h305, 32'h0, 1'b1, 1'b0, 32'h80000004);
    n_cmp++;
    if (csr_op !== 2'd0) begin n_bad++; $display("FAIL csrrs_read_op: got %0d want 0", csr_op); end
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL csrrs_mtvec_resp: got %h want %h ok=%b", got, want, ok); end

    // mstatus: preset, read, clear, read back
    send(3'd0, 12'h300, 32'h00000088, 1'b0, 1'b1, 32'h80000008);
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL csrrw_rdzero_resp: got %h want %h ok=%b", got, want, ok); end
    send(3'd1, 12'h300, 32'h0, 1'b1, 1'b0, 32'h8000000c);
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL csrrs_mstatus_resp: got %h want %h ok=%b", got, want, ok); end
    send(3'd2, 12'h300, 32'h00000008, 1'b0, 1'b0, 32'h80000010);
    n_cmp++;
    if (csr_op !== 2'd3) begin n_bad++; $display("FAIL csrrc_op: got %0d want 3", csr_op); end
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL csrrc_resp: got %h want %h ok=%b", got, want, ok); end
    send(3'd1, 12'h300, 32'h0, 1'b1, 1'b0, 32'h80000014);
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL csrrc_readback: got %h want %h ok=%b", got, want, ok); end

    // preset mepc for the MRET test
    send(3'd0, 12'h341, 32'h80000044, 1'b0, 1'b1, 32'h80000018);
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL mepc_write_resp: got %h want %h ok=%b", got, want, ok); end
  endtask

  task automatic test_ecall();
    resp_t got, want; bit ok;
    send(3'd3, 12'h000, 32'h0, 1'b0, 1'b0, 32'h80000040);
    n_cmp++;
    if ({ecall, mret, csr_enable, csr_pc, csr_name} !== {3'b100, 32'h80000040, 12'h305}) begin
      n_bad++; $display("FAIL ecall_pulse: got ecall=%b mret=%b en=%b pc=%h name=%h", ecall, mret, csr_enable, csr_pc, csr_name);
    end
    step();
    n_cmp++;
    if (ecall !== 1'b0) begin n_bad++; $display("FAIL ecall_one_cycle: got %b want 0", ecall); end
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL ecall_resp: got %h want %h ok=%b", got, want, ok); end
  endtask

  task automatic test_mret();
    resp_t got, want; bit ok;
    send(3'd4, 12'h000, 32'h0, 1'b0, 1'b0, 32'h80000050);
    n_cmp++;
    if ({mret, ecall, csr_enable, csr_name} !== {3'b100, 12'h341}) begin
      n_bad++; $display("FAIL mret_pulse: got mret=%b ecall=%b en=%b name=%h", mret, ecall, csr_enable, csr_name);
    end
    step();
    n_cmp++;
    if (mret !== 1'b0) begin n_bad++; $display("FAIL mret_one_cycle: got %b want 0", mret); end
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL mret_resp: got %h want %h ok=%b", got, want, ok); end
  endtask

  task automatic test_fence();
    resp_t got, want; bit ok;
    logic [148:0] snap;
    int req_cycles;
    // ack delayed: raised in the 5th FENCE cycle
    send(3'd5, 12'h000, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFC);
    req_cycles = 0;
    for (int k = 1; k <= 5; k++) begin
      if (fencei_req === 1'b1) req_cycles++;
      if (k == 5) fencei_ack = 1'b1;
      step();
    end
    fencei_ack = 1'b0;
    n_cmp++;
    if (req_cycles != 5) begin n_bad++; $display("FAIL fence_req_cycles: got %0d want 5", req_cycles); end
    n_cmp++;
    if ({fencei_req, out_valid} !== 2'b01) begin
      n_bad++; $display("FAIL fence_done: got req=%b valid=%b want req=0 valid=1", fencei_req, out_valid);
    end
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL fence_resp: got %h want %h ok=%b", got, want, ok); end

    // ack in the first FENCE cycle, then 3 cycles of backpressure
    send(3'd5, 12'h000, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFC);
    fencei_ack = 1'b1;
    step();
    fencei_ack = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fence_first_ack: got valid=%b want 1", out_valid); end
    snap = all_outs();
    for (int s = 0; s < 3; s++) begin
      step();
      n_cmp++;
      if (all_outs() !== snap) begin n_bad++; $display("FAIL backpressure_stable: got %h want %h", all_outs(), snap); end
    end
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL fence_bp_resp: got %h want %h ok=%b", got, want, ok); end
  endtask

  task automatic test_back_to_back();
    resp_t got, want; bit ok;
    send(3'd6, 12'h000, 32'h0, 1'b0, 1'b0, 32'h80000060);
    n_cmp++;
    if ({out_valid, csr_enable, ecall, mret} !== 4'b1000) begin
      n_bad++; $display("FAIL nop_timing: got valid=%b en=%b ecall=%b mret=%b", out_valid, csr_enable, ecall, mret);
    end
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL nop_resp: got %h want %h ok=%b", got, want, ok); end

    // busy offer of an ECALL plus a stale ack must both be ignored
    send(3'd1, 12'h300, 32'h0, 1'b1, 1'b0, 32'h80000064);
    in_valid = 1'b1; in_op = 3'd3; fencei_ack = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_in_ready: got %b want 0", in_ready); end
    step();
    in_valid = 1'b0; fencei_ack = 1'b0;
    n_cmp++;
    if ({ecall, fencei_req, out_valid} !== 3'b001) begin
      n_bad++; $display("FAIL busy_ignored: got ecall=%b req=%b valid=%b", ecall, fencei_req, out_valid);
    end
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL busy_resp: got %h want %h ok=%b", got, want, ok); end
  endtask

  task automatic test_reset_mid();
    resp_t got, want; bit ok;
    // reset while waiting in FENCE
    send(3'd5, 12'h000, 32'h0, 1'b0, 1'b0, 32'h80000070);
    void'(sb.pop_back());
    step();
    reset = 1'b1;
    step();
    n_cmp++;
    if (all_outs() !== '0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_fence: got %h ready=%b want 0", all_outs(), in_ready);
    end
    reset = 1'b0;
    step();
    send(3'd1, 12'h305, 32'h0, 1'b1, 1'b0, 32'h80000074);
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL post_reset_fence_resp: got %h want %h ok=%b", got, want, ok); end

    // reset while holding a response
    send(3'd3, 12'h000, 32'h0, 1'b0, 1'b0, 32'h80000078);
    void'(sb.pop_back());
    step();
    reset = 1'b1;
    step();
    n_cmp++;
    if (all_outs() !== '0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_resp: got %h ready=%b want 0", all_outs(), in_ready);
    end
    reset = 1'b0;
    step();
    send(3'd4, 12'h000, 32'h0, 1'b0, 1'b0, 32'h8000007c);
    collect(got, ok); want = sb.pop_front();
    n_cmp++;
    if (!ok || got !== want) begin n_bad++; $display("FAIL post_reset_resp: got %h want %h ok=%b", got, want, ok); end
  endtask

  initial begin
    test_reset();
    test_csr();
    test_ecall();
    test_mret();
    test_fence();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
